// File: rtl/uart_pkg.sv
// Shared UART definitions for the RX and TX sides.
// Holds the receiver FSM state encoding and the default frame geometry.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous line.
// Both flops reset to the line's idle level.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_16x.sv
// UART receiver with oversampled mid-bit sampling, LSB-first payload, one stop bit.
// Reports each frame as a one-clock rx_valid or frame_err pulse.
module uart_rx_16x
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_16x,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_t          state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [DATA_BITS-1:0] shreg;
  logic                 wait_high, wait_high_n;
  logic                 shift_en, done_ok, done_err;

  sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      wait_high <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      wait_high <= wait_high_n;
      rx_valid  <= done_ok;
      frame_err <= done_err;
      if (shift_en)
        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      if (done_ok)
        rx_data <= shreg;
    end
  end

  // After a low stop bit the line must be seen high before a new start edge counts,
  // so a held break produces a single frame error.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    wait_high_n = wait_high;
    shift_en    = 1'b0;
    done_ok     = 1'b0;
    done_err    = 1'b0;
    if (tick_16x) begin
      case (state)
        ST_IDLE: begin
          if (rx_s) begin
            wait_high_n = 1'b0;
          end else if (!wait_high) begin
            state_n = ST_START;
            cnt_n   = '0;
          end
        end
        ST_START: begin
          if (cnt == CNT_MID) begin
            cnt_n = '0;
            idx_n = '0;
            state_n = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            shift_en = 1'b1;
            cnt_n    = '0;
            idx_n    = idx + 1'b1;
            if (idx == IDX_LAST)
              state_n = ST_STOP;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt_n   = '0;
            state_n = ST_IDLE;
            if (rx_s) begin
              done_ok = 1'b1;
            end else begin
              done_err    = 1'b1;
              wait_high_n = 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_16x.sv
// Scoreboard bench for uart_rx_16x: frames are driven bit-by-bit at 160 clk per bit and
// the expected outcome of each frame is queued for a monitor that checks every output pulse.
module tb_uart_rx_16x;

  localparam int BIT_CLKS = 160;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_16x = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  exp_t       exp_q[$];
  exp_t       cur;
  logic [7:0] last_good = 8'h00;
  bit         prev_pulse = 1'b0;

  uart_rx_16x #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_16x  (tick_16x),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // One-clock oversample tick every 10 clocks
  initial begin
    forever begin
      repeat (9) @(negedge clk);
      tick_16x = 1'b1;
      @(negedge clk);
      tick_16x = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog simulation did not finish actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Queue the model's verdict for one frame, then drive it: start, LSB-first data, stop, idle gap
  task automatic applyStimulus(input logic [7:0] d, input bit stop, input int gap_clks);
    exp_t e;
    if (stop) begin
      e.is_err  = 1'b0;
      e.data    = d;
      last_good = d;
    end else begin
      e.is_err = 1'b1;
      e.data   = last_good;
    end
    exp_q.push_back(e);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT_CLKS / 2) @(negedge clk);
      if (i == 2)
        checkOutput("busy_mid_frame", {31'd0, busy}, 32'd1);
      repeat (BIT_CLKS / 2) @(negedge clk);
    end
    rx = stop;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (gap_clks) @(negedge clk);
  endtask

  // Monitor: every output pulse consumes one expectation
  initial begin
    forever begin
      @(negedge clk);
      if (prev_pulse)
        checkOutput("pulse_width", {30'd0, rx_valid, frame_err}, 32'd0);
      prev_pulse = rx_valid | frame_err;
      if (rx_valid || frame_err) begin
        checkOutput("valid_err_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_pulse actual valid=%0b err=%0b data=%02h required=no_pulse",
                   rx_valid, frame_err, rx_data);
        end else begin
          cur = exp_q.pop_front();
          checkOutput("pulse_kind_err", {31'd0, frame_err}, {31'd0, cur.is_err});
          checkOutput("rx_data", {24'd0, rx_data}, {24'd0, cur.data});
        end
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic [7:0] partial;
    bit         stop;
    int         gap;

    repeat (4) @(negedge clk);
    checkOutput("reset_rx_data", {24'd0, rx_data}, 32'd0);
    checkOutput("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge clk);

    applyStimulus(8'hA5, 1'b1, 2 * BIT_CLKS);
    checkOutput("busy_after_frame", {31'd0, busy}, 32'd0);

    // Short glitch: rejected at the mid-start check
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("busy_after_false_start", {31'd0, busy}, 32'd0);
    repeat (2 * BIT_CLKS) @(negedge clk);

    applyStimulus(8'h3C, 1'b0, 2 * BIT_CLKS);
    applyStimulus(8'h00, 1'b1, 0);
    applyStimulus(8'hFF, 1'b1, 2 * BIT_CLKS);

    // Reset in the middle of data bit 4; the partial frame must vanish
    partial = 8'h96;
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rx = partial[i];
      repeat ((i == 4) ? BIT_CLKS / 2 : BIT_CLKS) @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checkOutput("async_reset_rx_data", {24'd0, rx_data}, 32'd0);
    checkOutput("async_reset_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("async_reset_err", {31'd0, frame_err}, 32'd0);
    checkOutput("async_reset_busy", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    repeat (2 * BIT_CLKS) @(negedge clk);
    applyStimulus(8'h5A, 1'b1, 2 * BIT_CLKS);

    // Break: one frame error, then stay idle while the line is held low
    cur.is_err = 1'b1;
    cur.data   = last_good;
    exp_q.push_back(cur);
    rx = 1'b0;
    repeat (20 * BIT_CLKS) @(negedge clk);
    checkOutput("busy_during_break", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    applyStimulus(8'h81, 1'b1, 2 * BIT_CLKS);

    // Random frames; after a bad stop bit the line idles for at least one bit
    for (int n = 0; n < 20; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      gap  = stop ? int'($urandom_range(0, 200)) : int'($urandom_range(170, 400));
      applyStimulus(d, stop, gap);
    end

    repeat (3 * BIT_CLKS) @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_16x.md
UART_RX_16X -- requirements
Module: uart_rx_16x

Interface
REQ-001 Parameter DATA_BITS, default 8: payload bits per frame, LSB first.
REQ-002 Parameter OVERSAMPLE, default 16: tick_16x pulses per bit period.
REQ-003 clk  input  1  system clock; all state on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 tick_16x  input  1  oversample enable; one-clk pulse at 16x baud.
REQ-006 rx  input  1  asynchronous serial line; idles high.
REQ-007 rx_data  output  DATA_BITS  last correctly framed byte.
REQ-008 rx_valid  output  1  one-clk pulse when rx_data is updated.
REQ-009 frame_err  output  1  one-clk pulse when a stop bit is sampled low.
REQ-010 busy  output  1  high whenever state is not IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer reset to 1; all decisions use the synchronized value rx_s.
REQ-012 State and sample counters SHALL advance only in cycles where tick_16x=1; other cycles hold state.
REQ-013 FSM states: IDLE, START, DATA, STOP.
REQ-014 IDLE: on a tick with rx_s=0 -> START, tick counter cleared to 0.
REQ-015 START: on the tick where counter reaches OVERSAMPLE/2-1 (mid start bit), rx_s=0 -> DATA with counter and bit index cleared; rx_s=1 -> IDLE (false start, no output).
REQ-016 DATA: every OVERSAMPLE ticks (counter = OVERSAMPLE-1), sample rx_s into shift register LSB first and clear the counter; after DATA_BITS samples -> STOP.
REQ-017 STOP: at counter = OVERSAMPLE-1, sample rx_s; 1 -> load rx_data from shift register and pulse rx_valid; 0 -> pulse frame_err, rx_data unchanged; either way -> IDLE.
REQ-018 rx_valid and frame_err SHALL be registered, high for exactly one clk in the cycle after the stop-sampling tick, never both high.
REQ-019 rx_data SHALL hold its value until the next valid frame.
REQ-020 The next start bit SHALL be detected on the first tick after returning to IDLE (no extra idle time required between frames).
REQ-021 Counter widths: $clog2(OVERSAMPLE) bits for ticks, $clog2(DATA_BITS+1) bits for bit index; no wrap outside the stated compare points.
REQ-022 A low break on the line SHALL yield frame_err and then restart frame detection only after rx_s returns high then low.

Reset
REQ-023 Asserting rst at any time, including mid-frame, SHALL immediately force IDLE, counters 0, shift register 0, rx_data=0, rx_valid=0, frame_err=0, busy=0, synchronizer flops=1.
REQ-024 After rst deasserts, no output pulse SHALL occur until a complete new frame is received.

Structure
REQ-025 FSM state encoding and the OVERSAMPLE/DATA_BITS defaults SHALL live in a shared uart package used by the TX side as well.
REQ-026 The synchronizer SHALL be a sub-module named sync_2ff; the rest is flat.

Verification (tick_16x every 10 clk, so 1 bit = 160 clk)
REQ-027 Frame 0xA5, stop=1 -> rx_data=0xA5, rx_valid one clk, frame_err=0, busy low afterwards.
REQ-028 rx low for 3 ticks (30 clk) then high -> no rx_valid, no frame_err, return to IDLE by tick 8.
REQ-029 Frame 0x3C with stop=0 -> frame_err one clk, rx_valid=0, rx_data keeps previous value.
REQ-030 Back-to-back 0x00 then 0xFF with 1 stop bit, no gap -> two rx_valid pulses, data 0x00 then 0xFF.
REQ-031 rst pulsed during bit 4 of a frame -> all outputs 0 asynchronously; partial frame discarded; following frame 0x5A received correctly.
REQ-032 Break (rx low for 20 bit times) -> exactly one frame_err, no rx_valid, then 0x81 received after line idles high.
